// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Entry n is the a..g pattern (bit 0 = a) for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment pattern decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one 7-segment digit between NUM_REQ status requesters:
// grant, show for a dwell period, blank for a gap, then return to idle.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [4*NUM_REQ-1:0]       data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [6:0]                 segments,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_ID    = IW'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [DW-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [BW-1:0]      blank_cnt_q, blank_cnt_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      cur_id_q, cur_id_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [6:0]         seg_q, seg_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [IW-1:0]      pick_id;
    logic [3:0]         pick_nibble;
    logic [6:0]         pick_seg;
    int                 idx;

    // First requesting index at or above rr_ptr, wrapping past the top.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = IW'(idx);
            end
        end
    end

    assign pick_nibble = data[4*pick_id +: 4];

    hex_to_seg7 u_dec (
        .hex (pick_nibble),
        .seg (pick_seg)
    );

    always_comb begin
        state_d     = state_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        ack_d       = '0;
        seg_d       = seg_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = SHOW;
                    ack_d       = NUM_REQ'(1) << pick_id;
                    cur_id_d    = pick_id;
                    seg_d       = pick_seg;
                    busy_d      = 1'b1;
                    dwell_cnt_d = DWELL_LOAD;
                end
            end
            SHOW: begin
                if (dwell_cnt_q == '0) begin
                    rr_ptr_d = (cur_id_q == LAST_ID) ? '0 : cur_id_q + IW'(1);
                    seg_d    = SEG_BLANK;
                    if (BLANK_CYCLES > 0) begin
                        state_d     = BLANK;
                        blank_cnt_d = BLANK_LOAD;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DW'(1);
                end
            end
            BLANK: begin
                if (blank_cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    blank_cnt_d = blank_cnt_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                seg_d   = SEG_BLANK;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            ack_q       <= '0;
            seg_q       <= SEG_BLANK;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            ack_q       <= ack_d;
            seg_q       <= seg_d;
            busy_q      <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign segments = seg_q;
    assign busy     = busy_q;
    assign cur_id   = cur_id_q;

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-shares the 7-segment output between several on-chip status requesters, so one digit can show the hex nibble of whichever subsystem currently owns it. Requesters raise a request with a 4-bit value. The block grants them round-robin, acknowledges each with a one-cycle pulse, and shows the value for a fixed dwell period followed by a blank gap. It sits between the core's status sources and the top-level `segments` output (`io_out[6:0]`).

## Interface
- `NUM_REQ`, default 4: number of requesters; must be at least 2.
- `DWELL_CYCLES`, default 1024: cycles a granted value is shown; must be at least 1.
- `BLANK_CYCLES`, default 2: cycles of blank display after each dwell; 0 is legal.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `req`  in  `NUM_REQ`: per-requester request level.
- `data`  in  `4*NUM_REQ`: nibble of requester i at `data[4i+3:4i]`.
- `ack`  out  `NUM_REQ`: one-hot, one-cycle grant/capture pulse.
- `segments`  out  7: active-high segment drive; bit 0 = a … bit 6 = g.
- `busy`  out  1: high while a value is shown or blanking.
- `cur_id`  out  `$clog2(NUM_REQ)`: index of the last granted requester.

## Operation
- FSM states: IDLE, SHOW, BLANK.
- IDLE → SHOW happens when `req` is nonzero. On that edge the block:
  - grants the first requester with `req` high, scanning from `rr_ptr` upward with wrap-around;
  - latches its nibble;
  - sets `ack[grant]`, `cur_id`, `segments = decode(nibble)` and `busy`;
  - loads the dwell counter with `DWELL_CYCLES-1`.
- SHOW:
  - decrements the dwell counter each cycle;
  - at zero, goes to BLANK (`segments` = 0) if `BLANK_CYCLES > 0`, else to IDLE;
  - on leaving SHOW, sets `rr_ptr = (grant+1) mod NUM_REQ`.
- BLANK:
  - holds `segments` = 0 for `BLANK_CYCLES` cycles, then goes to IDLE with `busy` = 0.
- IDLE output: `segments` = 0, `busy` = 0.
- Decode, hex 0–F → segments: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Requester rules:
  - hold `req` and `data` stable until its `ack`;
  - dropping `req` before `ack` withdraws the request, and no `ack` is issued;
  - `req` still high after `ack` is a new request, served in round-robin order.
- Requests arriving during SHOW or BLANK are ignored until IDLE; they are not queued.
- Dwell counter width is `$clog2(DWELL_CYCLES)` (minimum 1). No wrap or overflow is possible.

## Timing
- Reset values: `segments` = 0, `ack` = 0, `busy` = 0, `cur_id` = 0, `rr_ptr` = 0, state IDLE, counters 0.
- Reset asserted mid-dwell or mid-blank clears everything immediately and asynchronously. The first grant after release starts the round-robin scan again at index 0.
- Grant latency: `req` sampled high at edge k in IDLE gives `ack`, `segments` and `busy` valid after edge k. `ack` is high for exactly cycle k..k+1.
- Displayed value is held for exactly `DWELL_CYCLES` cycles.
- Blank gap is exactly `BLANK_CYCLES` cycles.
- IDLE lasts at least one cycle between grants. Back-to-back grant period is therefore `DWELL_CYCLES + BLANK_CYCLES + 1` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `seg_pkg`:
  - state enum (IDLE, SHOW, BLANK);
  - 16-entry hex-to-segment constant array;
  - `SEG_BLANK` = 7'h00.
- Sub-module `hex_to_seg7`: combinational 4→7 decoder built from the package constants, reused elsewhere in the core.
- The round-robin pick stays inline in the scheduler.

## Test plan
All scenarios use `NUM_REQ`=4, `DWELL_CYCLES`=4, `BLANK_CYCLES`=2.
- Reset: hold `rst`=0 with `req`=4'hF. Required: `segments`=0, `ack`=0, `busy`=0, `cur_id`=0 throughout.
- Single request: `req`=4'b0100 with nibble 4'hA. Required: `ack`=4'b0100 for 1 cycle, `segments`=7'h77 for 4 cycles, then 7'h00 for 2 cycles, `busy` falling after the blank, `cur_id`=2.
- Round-robin: all four `req` held high with nibbles 1, 2, 3, 4. Required:
  - grant order 0, 1, 2, 3, 0;
  - segments sequence 06, 5B, 4F, 66;
  - grant period of 7 cycles.
- Withdrawal: `req[1]` raised during a dwell for requester 0, then dropped before IDLE. Required: `ack[1]` is never asserted, and the block returns to IDLE.
- Reset mid-dwell: `rst`=0 for 1 cycle, 2 cycles into displaying 4'h8. Required:
  - `segments`, `busy` and `ack` go to 0 immediately;
  - with `req`=4'b1001 after release, the next grant goes to requester 0.
- Zero blank (`BLANK_CYCLES`=0): two requesters held high. Required: SHOW → IDLE → SHOW, with `segments` 0 for exactly 1 IDLE cycle between values.
